pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it decides which registers load, which load a bubble, and which hold. It resolves data-cache stalls, taken-branch flushes, load-use hazards and instruction-cache stalls by priority. A small FSM drains the pipeline after a halt reaches EX/MEM and then freezes it.

## Interface
- DRAIN_CYCLES, 1: cycles in DRAIN before HALTED; legal range 1..15.
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dcache_req  in  1  MEM stage holds a valid load/store.
- dcache_ready  in  1  data cache completes the MEM access this cycle.
- icache_ready  in  1  instruction cache delivers the fetched word this cycle.
- ex_branch_taken  in  1  EX resolved a redirect (taken branch, jal, jalr, or mispredict).
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of ID/EX.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
- id_rs1, id_rs2  in  5 each  ID source register ids.
- exmem_is_halted  in  1  is_halted bit of the EX/MEM register.
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all control bits 0); overrides the matching write.
- halted  out  1  pipeline frozen after halt.
- stall_count  out  32  cycles with pc_write=0 (see Configuration).

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and inputs.
- Conditions:
  - mem_stall = dcache_req & ~dcache_ready.
  - load_use = idex_mem_read & (idex_rd!=0) & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
- Default in RUN: all writes 1, all flushes 0.
- Priority in RUN and MEM_WAIT, highest first:
  1. mem_stall: pc/ifid/idex/exmem writes 0; memwb_flush=1. Next state MEM_WAIT.
  2. ex_branch_taken: pc_write=1 (loads target), ifid_flush=1, idex_flush=1, EX/MEM and MEM/WB advance.
  3. exmem_is_halted: pc_write=0, ifid_flush=1, idex_flush=1, EX/MEM and MEM/WB advance. Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
  4. load_use: pc_write=0, ifid_write=0, idex_flush=1, older stages advance.
  5. ~icache_ready: pc_write=0, ifid_flush=1, others advance.
- MEM_WAIT: holds while mem_stall. In the cycle dcache_ready rises, RUN rules apply and next state is RUN (or DRAIN if rule 3 fires).
- DRAIN:
  - pc_write=0, ifid_flush=1, idex_flush=1. EX/MEM advances with exmem_flush=1. MEM/WB advances.
  - Counter decrements each cycle; the cycle it reads 1, next state is HALTED.
  - mem_stall in DRAIN freezes the counter and applies rule-1 outputs.
- HALTED: all writes 0, all flushes 0, halted=1. Exits only on reset.
- ex_branch_taken and exmem_is_halted together: rule 2 outputs apply and the state still goes to DRAIN. The redirect is harmless because fetch is then squashed.

## Timing
- Reset asserted, asynchronously:
  - state=RUN, drain counter=0, stall_count=0.
  - All writes 0, all flushes 1, halted=0.
- Reset released: normal RUN evaluation starts from the first rising edge.
- Zero-latency control: every output reflects the current cycle's inputs. The registers sample on the same edge.
- halted rises exactly DRAIN_CYCLES+1 cycles after the first cycle exmem_is_halted is seen with no mem_stall, excluding mem-stall cycles.
- Reset mid-DRAIN or mid-MEM_WAIT returns to RUN immediately; no partial state survives.
- Load-use stall lasts one cycle. The next cycle, ID/EX holds a bubble, so load_use deasserts.

## Configuration
- PIPE_STALL_COUNTER_EN defined:
  - stall_count increments by 1 on each rising edge where pc_write=0 and state!=HALTED.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: stall_count tied to 0, no counter flops.

## Test plan
- Load-use: idex_mem_read=1, idex_rd=5, id_uses_rs1=1, id_rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle all writes 1. Repeat with idex_rd=0 -> no stall.
- D-cache miss: dcache_req=1, dcache_ready=0 for 4 cycles -> 4 cycles of all writes 0 except memwb_flush=1; dcache_ready=1 -> RUN outputs; stall_count=4 (macro on).
- Branch during I-cache miss: icache_ready=0, ex_branch_taken=1 -> pc_write=1, ifid_flush=1, idex_flush=1.
- Halt: exmem_is_halted=1, DRAIN_CYCLES=2 -> 2 DRAIN cycles with exmem_flush=1, then halted=1 and all writes 0 persist.
- Mem stall inside DRAIN: dcache_req=1, dcache_ready=0 for 3 cycles mid-DRAIN -> halted delayed by exactly 3 cycles.
- Async reset asserted mid-MEM_WAIT, not on a clock edge -> outputs immediately all writes 0, all flushes 1; after release, state RUN and stall_count=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall sequencer for the five-stage pipeline registers and PC.
// Optional macro PIPE_STALL_COUNTER_EN enables the saturating stall-cycle counter.
module pipeline_hazard_controller #(
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_dcache_req,
   input  logic        i_dcache_ready,
   input  logic        i_icache_ready,
   input  logic        i_ex_branch_taken,
   input  logic        i_idex_mem_read,
   input  logic [4:0]  i_idex_rd,
   input  logic        i_id_uses_rs1,
   input  logic        i_id_uses_rs2,
   input  logic [4:0]  i_id_rs1,
   input  logic [4:0]  i_id_rs2,
   input  logic        i_exmem_is_halted,
   output logic        o_pc_write,
   output logic        o_ifid_write,
   output logic        o_idex_write,
   output logic        o_exmem_write,
   output logic        o_memwb_write,
   output logic        o_ifid_flush,
   output logic        o_idex_flush,
   output logic        o_exmem_flush,
   output logic        o_memwb_flush,
   output logic        o_halted,
   output logic [31:0] o_stall_count
);

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM_WAIT,
      S_DRAIN,
      S_HALTED
   } state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_drain_cnt;
   logic [3:0] w_drain_cnt_next;
   logic       w_mem_stall;
   logic       w_load_use;

   assign w_mem_stall = i_dcache_req & ~i_dcache_ready;
   assign w_load_use  = i_idex_mem_read && (i_idex_rd != 5'd0) &&
                        ((i_id_uses_rs1 && (i_id_rs1 == i_idex_rd)) ||
                         (i_id_uses_rs2 && (i_id_rs2 == i_idex_rd)));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_cnt_next;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      o_pc_write       = 1'b1;
      o_ifid_write     = 1'b1;
      o_idex_write     = 1'b1;
      o_exmem_write    = 1'b1;
      o_memwb_write    = 1'b1;
      o_ifid_flush     = 1'b0;
      o_idex_flush     = 1'b0;
      o_exmem_flush    = 1'b0;
      o_memwb_flush    = 1'b0;
      o_halted         = 1'b0;
      w_state_next     = r_state;
      w_drain_cnt_next = r_drain_cnt;

      case (r_state)
         S_RUN, S_MEM_WAIT: begin
            w_state_next = S_RUN;
            if (w_mem_stall) begin
               o_pc_write    = 1'b0;
               o_ifid_write  = 1'b0;
               o_idex_write  = 1'b0;
               o_exmem_write = 1'b0;
               o_memwb_flush = 1'b1;
               w_state_next  = S_MEM_WAIT;
            end else if (i_ex_branch_taken) begin
               o_ifid_flush = 1'b1;
               o_idex_flush = 1'b1;
               // A halt arriving with a redirect still drains; fetch is squashed anyway.
               if (i_exmem_is_halted) begin
                  w_state_next     = S_DRAIN;
                  w_drain_cnt_next = DRAIN_INIT;
               end
            end else if (i_exmem_is_halted) begin
               o_pc_write       = 1'b0;
               o_ifid_flush     = 1'b1;
               o_idex_flush     = 1'b1;
               w_state_next     = S_DRAIN;
               w_drain_cnt_next = DRAIN_INIT;
            end else if (w_load_use) begin
               o_pc_write   = 1'b0;
               o_ifid_write = 1'b0;
               o_idex_flush = 1'b1;
            end else if (!i_icache_ready) begin
               o_pc_write   = 1'b0;
               o_ifid_flush = 1'b1;
            end
         end

         S_DRAIN: begin
            if (w_mem_stall) begin
               o_pc_write    = 1'b0;
               o_ifid_write  = 1'b0;
               o_idex_write  = 1'b0;
               o_exmem_write = 1'b0;
               o_memwb_flush = 1'b1;
            end else begin
               o_pc_write       = 1'b0;
               o_ifid_flush     = 1'b1;
               o_idex_flush     = 1'b1;
               o_exmem_flush    = 1'b1;
               w_drain_cnt_next = r_drain_cnt - 4'd1;
               if (r_drain_cnt == 4'd1) begin
                  w_state_next = S_HALTED;
               end
            end
         end

         S_HALTED: begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_write  = 1'b0;
            o_exmem_write = 1'b0;
            o_memwb_write = 1'b0;
            o_halted      = 1'b1;
         end

         default: begin
            w_state_next = S_RUN;
         end
      endcase

      // While reset is held the pipeline registers are kept empty.
      if (!i_rst_n) begin
         o_pc_write    = 1'b0;
         o_ifid_write  = 1'b0;
         o_idex_write  = 1'b0;
         o_exmem_write = 1'b0;
         o_memwb_write = 1'b0;
         o_ifid_flush  = 1'b1;
         o_idex_flush  = 1'b1;
         o_exmem_flush = 1'b1;
         o_memwb_flush = 1'b1;
         o_halted      = 1'b0;
      end
   end

`ifdef PIPE_STALL_COUNTER_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= 32'd0;
      end else if (!o_pc_write && (r_state != S_HALTED) && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign o_stall_count = r_stall_count;
`else
   assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a rule-level model.
module tb_pipeline_hazard_controller;

   localparam int unsigned D = 2;

   typedef struct packed {
      logic       dreq;
      logic       drdy;
      logic       irdy;
      logic       br;
      logic       mr;
      logic [4:0] rd;
      logic       u1;
      logic       u2;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       hlt;
   } in_t;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
      logic f_ifid;
      logic f_idex;
      logic f_exmem;
      logic f_memwb;
      logic halted;
   } out_t;

   logic        clk;
   logic        rst_n;
   logic        dcache_req, dcache_ready, icache_ready, ex_branch_taken, idex_mem_read;
   logic [4:0]  idex_rd, id_rs1, id_rs2;
   logic        id_uses_rs1, id_uses_rs2, exmem_is_halted;
   logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
   logic [31:0] stall_count;

   int          n_vec = 0;
   int          n_bad = 0;
   logic        obs_halted;

   // Reference state: remaining drain cycles (0 = not draining), frozen flag, stall tally.
   int          m_drain;
   bit          m_halted;
   logic [31:0] m_stall;

   pipeline_hazard_controller #(.DRAIN_CYCLES(D)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_dcache_req     (dcache_req),
      .i_dcache_ready   (dcache_ready),
      .i_icache_ready   (icache_ready),
      .i_ex_branch_taken(ex_branch_taken),
      .i_idex_mem_read  (idex_mem_read),
      .i_idex_rd        (idex_rd),
      .i_id_uses_rs1    (id_uses_rs1),
      .i_id_uses_rs2    (id_uses_rs2),
      .i_id_rs1         (id_rs1),
      .i_id_rs2         (id_rs2),
      .i_exmem_is_halted(exmem_is_halted),
      .o_pc_write       (pc_write),
      .o_ifid_write     (ifid_write),
      .o_idex_write     (idex_write),
      .o_exmem_write    (exmem_write),
      .o_memwb_write    (memwb_write),
      .o_ifid_flush     (ifid_flush),
      .o_idex_flush     (idex_flush),
      .o_exmem_flush    (exmem_flush),
      .o_memwb_flush    (memwb_flush),
      .o_halted         (halted),
      .o_stall_count    (stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic in_t idle();
      in_t v;
      v      = '0;
      v.drdy = 1'b1;
      v.irdy = 1'b1;
      return v;
   endfunction

   task automatic drive(input in_t v);
      dcache_req      = v.dreq;
      dcache_ready    = v.drdy;
      icache_ready    = v.irdy;
      ex_branch_taken = v.br;
      idex_mem_read   = v.mr;
      idex_rd         = v.rd;
      id_uses_rs1     = v.u1;
      id_uses_rs2     = v.u2;
      id_rs1          = v.rs1;
      id_rs2          = v.rs2;
      exmem_is_halted = v.hlt;
   endtask

   function automatic out_t observe();
      out_t o;
      o = '{pc_write, ifid_write, idex_write, exmem_write, memwb_write,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
      return o;
   endfunction

   function automatic out_t model_out(input in_t v);
      out_t e;
      bit   ms, lu;
      ms = v.dreq && !v.drdy;
      lu = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      if (m_halted) begin
         e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      end else if (ms) begin
         e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.f_memwb = 1;
      end else if (m_drain > 0) begin
         e.pc = 0; e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
      end else if (v.br) begin
         e.f_ifid = 1; e.f_idex = 1;
      end else if (v.hlt) begin
         e.pc = 0; e.f_ifid = 1; e.f_idex = 1;
      end else if (lu) begin
         e.pc = 0; e.ifid = 0; e.f_idex = 1;
      end else if (!v.irdy) begin
         e.pc = 0; e.f_ifid = 1;
      end
      return e;
   endfunction

   task automatic model_step(input in_t v, input out_t e);
      bit ms;
      ms = v.dreq && !v.drdy;
      if (!m_halted && !e.pc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (!m_halted && !ms) begin
         if (m_drain > 0) begin
            m_drain = m_drain - 1;
            if (m_drain == 0) m_halted = 1;
         end else if (v.hlt) begin
            m_drain = D;
         end
      end
   endtask

   function automatic logic [31:0] exp_stall();
`ifdef PIPE_STALL_COUNTER_EN
      return m_stall;
`else
      return 32'd0;
`endif
   endfunction

   // One clock: drive after the edge, compare at the falling edge, advance the model.
   task automatic cycle(input in_t v);
      out_t e, o;
      drive(v);
      @(negedge clk);
      e = model_out(v);
      o = observe();
      obs_halted = halted;
      n_vec++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL ctrl_outputs t=%0t got %b expected %b", $time, o, e);
      end
      n_vec++;
      if (stall_count !== exp_stall()) begin
         n_bad++;
         $display("FAIL stall_count t=%0t got %0d expected %0d", $time, stall_count, exp_stall());
      end
      model_step(v, e);
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between clock edges, checks the forced outputs, then releases mid-cycle.
   task automatic do_reset();
      out_t exp_rst;
      #3;
      rst_n = 1'b0;
      #1;
      exp_rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      n_vec++;
      if (observe() !== exp_rst) begin
         n_bad++;
         $display("FAIL reset_outputs t=%0t got %b expected %b", $time, observe(), exp_rst);
      end
      n_vec++;
      if (stall_count !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_stall_count got %0d expected 0", stall_count);
      end
      m_drain  = 0;
      m_halted = 0;
      m_stall  = 32'd0;
      drive(idle());
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(idle());
      do_reset();
      cycle(idle());
   endtask

   task automatic test_load_use();
      in_t v;
      v = idle();
      v.mr = 1; v.rd = 5'd5; v.u1 = 1; v.rs1 = 5'd5;
      cycle(v);
      cycle(idle());
      v.rd = 5'd0; v.rs1 = 5'd0;
      cycle(v);
      v = idle();
      v.mr = 1; v.rd = 5'd9; v.u2 = 1; v.rs2 = 5'd9; v.irdy = 0;
      cycle(v);
   endtask

   task automatic test_dcache_miss();
      in_t v;
      v = idle();
      v.dreq = 1; v.drdy = 0;
      for (int k = 0; k < 4; k++) cycle(v);
      v.drdy = 1;
      cycle(v);
      cycle(idle());
   endtask

   task automatic test_branch_icache();
      in_t v;
      v = idle();
      v.irdy = 0; v.br = 1;
      cycle(v);
      v.br = 0;
      cycle(v);
   endtask

   task automatic test_random();
      in_t v;
      for (int k = 0; k < 400; k++) begin
         v      = '0;
         v.dreq = ($urandom_range(0, 2) == 0);
         v.drdy = ($urandom_range(0, 1) == 0);
         v.irdy = ($urandom_range(0, 3) != 0);
         v.br   = ($urandom_range(0, 5) == 0);
         v.mr   = ($urandom_range(0, 1) == 0);
         v.rd   = 5'($urandom_range(0, 3));
         v.u1   = ($urandom_range(0, 1) == 0);
         v.u2   = ($urandom_range(0, 1) == 0);
         v.rs1  = 5'($urandom_range(0, 3));
         v.rs2  = 5'($urandom_range(0, 3));
         v.hlt  = ($urandom_range(0, 119) == 0);
         cycle(v);
      end
      do_reset();
   endtask

   task automatic test_halt(input int stall_len);
      in_t v;
      int  t;
      t = -1;
      v = idle();
      v.hlt = 1;
      cycle(v);
      for (int k = 1; k <= 30; k++) begin
         v = idle();
         v.hlt = 1;
         if (k >= 2 && k < 2 + stall_len) begin
            v.dreq = 1; v.drdy = 0;
         end
         cycle(v);
         if (obs_halted) begin
            t = k;
            break;
         end
      end
      n_vec++;
      if (t != int'(D) + 1 + stall_len) begin
         n_bad++;
         $display("FAIL halt_latency got %0d cycles expected %0d", t, int'(D) + 1 + stall_len);
      end
      v = idle();
      v.br = 1; v.dreq = 1; v.drdy = 0;
      cycle(v);
      cycle(idle());
      do_reset();
   endtask

   task automatic test_branch_with_halt();
      in_t v;
      v = idle();
      v.br = 1; v.hlt = 1;
      cycle(v);
      for (int k = 0; k < 4; k++) cycle(idle());
      do_reset();
   endtask

   task automatic test_async_reset_mem_wait();
      in_t v;
      cycle(idle());
      v = idle();
      v.dreq = 1; v.drdy = 0;
      cycle(v);
      cycle(v);
      drive(v);
      do_reset();
      cycle(idle());
      v = idle();
      v.irdy = 0;
      cycle(v);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_dcache_miss();
      test_branch_icache();
      test_halt(0);
      test_halt(3);
      test_branch_with_halt();
      test_async_reset_mem_wait();
      test_random();
      test_load_use();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
